// File: rtl/ps2_kbd_rx_pkg.sv
// Shared definitions for the PS/2 keyboard receiver.
//   ps2_state_t  : frame FSM state encoding
//   PFX_EXT/REL  : scancode prefix bytes (extended key / key release)
//   key_entry_t  : one decoded key as stored in the key FIFO
//   parity_ok    : odd-parity check over a data byte plus its parity bit
package ps2_kbd_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } ps2_state_t;

    localparam logic [7:0] PFX_EXT = 8'hE0;
    localparam logic [7:0] PFX_REL = 8'hF0;

    typedef struct packed {
        logic       ext;
        logic       rel;
        logic [7:0] code;
    } key_entry_t;

    // Odd parity: data bits plus parity bit must hold an odd number of 1s.
    function automatic logic parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_key_fifo.sv
// First-word-fall-through FIFO for decoded keys.
//   clk, reset_n : system clock, async active-low reset
//   push         : write push_entry this cycle
//   push_entry   : entry to store
//   pop_ready    : consumer accepts the head when valid=1
//   valid        : head entry present (rises the cycle after a push into empty)
//   head         : head entry, all zero while valid=0
//   overflow     : one-cycle pulse when a push is dropped because the FIFO is full
module ps2_key_fifo
    import ps2_kbd_rx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       push,
    input  key_entry_t push_entry,
    input  logic       pop_ready,
    output logic       valid,
    output key_entry_t head,
    output logic       overflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    key_entry_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             pop;
    logic             do_push;

    assign full     = (count == CNT_W'(DEPTH));
    assign valid    = (count != '0);
    assign pop      = valid & pop_ready;
    // When full, a simultaneous pop frees the slot being written.
    assign do_push  = push & (~full | pop);
    assign overflow = push & full & ~pop;
    assign head     = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_entry;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            case ({do_push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronises and filters the PS/2 lines, deframes
// 11-bit frames, folds E0/F0 prefixes into flags and queues decoded keys.
//   clk, reset_n       : system clock, async active-low reset
//   ps2_clk, ps2_data  : asynchronous PS/2 lines (idle high)
//   key_valid/ready    : FIFO head handshake
//   key_code/ext/rel   : head entry (zero while key_valid=0)
//   frame_err          : one-cycle pulse on parity, stop or timeout error
//   overflow           : one-cycle pulse when a key is dropped on a full FIFO
module ps2_kbd_rx
    import ps2_kbd_rx_pkg::*;
#(
    parameter int FILTER_LEN = 4,
    parameter int TIMEOUT    = 43000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       key_valid,
    input  logic       key_ready,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_rel,
    output logic       frame_err,
    output logic       overflow
);

    localparam int FILT_W = $clog2(FILTER_LEN + 1);
    localparam int TO_W   = $clog2(TIMEOUT + 1);

    logic              ps2_clk_p0, ps2_clk_p1;
    logic              ps2_data_p0, ps2_data_p1;
    logic              filt_level, filt_prev;
    logic [FILT_W-1:0] filt_cnt;
    logic              fall;

    ps2_state_t        state;
    logic [2:0]        bit_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic [7:0]        shift;
    logic              par_bit;
    logic              ext_flag, rel_flag;
    logic              push;
    key_entry_t        push_entry;
    key_entry_t        head;

    // Stage p0/p1: two-flop synchronisers, reset to the idle-high bus level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ps2_clk_p0  <= 1'b1;
            ps2_clk_p1  <= 1'b1;
            ps2_data_p0 <= 1'b1;
            ps2_data_p1 <= 1'b1;
        end else begin
            ps2_clk_p0  <= ps2_clk;
            ps2_clk_p1  <= ps2_clk_p0;
            ps2_data_p0 <= ps2_data;
            ps2_data_p1 <= ps2_data_p0;
        end
    end

    // Glitch filter: the level moves only after FILTER_LEN consecutive samples
    // that disagree with it; any sample matching the current level restarts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_level <= 1'b1;
            filt_prev  <= 1'b1;
            filt_cnt   <= '0;
        end else begin
            filt_prev <= filt_level;
            if (ps2_clk_p1 == filt_level) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FILT_W'(FILTER_LEN - 1)) begin
                filt_level <= ps2_clk_p1;
                filt_cnt   <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    assign fall = filt_prev & ~filt_level;

    // Frame payload registers carry data only and need no reset.
    always_ff @(posedge clk) begin
        if (fall && state == ST_DATA)   shift   <= {ps2_data_p1, shift[7:1]};
        if (fall && state == ST_PARITY) par_bit <= ps2_data_p1;
        if (fall && state == ST_STOP)   push_entry <= {ext_flag, rel_flag, shift};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            to_cnt    <= '0;
            ext_flag  <= 1'b0;
            rel_flag  <= 1'b0;
            frame_err <= 1'b0;
            push      <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            push      <= 1'b0;
            if (state != ST_IDLE && !fall && to_cnt == TO_W'(TIMEOUT - 1)) begin
                // Bus stalled mid-frame: abandon the partial byte.
                state     <= ST_IDLE;
                to_cnt    <= '0;
                frame_err <= 1'b1;
                ext_flag  <= 1'b0;
                rel_flag  <= 1'b0;
            end else begin
                if (state != ST_IDLE)
                    to_cnt <= fall ? '0 : to_cnt + 1'b1;
                if (fall) begin
                    case (state)
                        ST_IDLE: begin
                            if (!ps2_data_p1) begin
                                state   <= ST_DATA;
                                bit_cnt <= '0;
                                to_cnt  <= '0;
                            end
                        end
                        ST_DATA: begin
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == 3'd7) state <= ST_PARITY;
                        end
                        ST_PARITY: state <= ST_STOP;
                        ST_STOP: begin
                            state  <= ST_IDLE;
                            to_cnt <= '0;
                            if (!ps2_data_p1 || !parity_ok(shift, par_bit)) begin
                                frame_err <= 1'b1;
                                ext_flag  <= 1'b0;
                                rel_flag  <= 1'b0;
                            end else if (shift == PFX_EXT) begin
                                ext_flag <= 1'b1;
                            end else if (shift == PFX_REL) begin
                                rel_flag <= 1'b1;
                            end else begin
                                push     <= 1'b1;
                                ext_flag <= 1'b0;
                                rel_flag <= 1'b0;
                            end
                        end
                        default: state <= ST_IDLE;
                    endcase
                end
            end
        end
    end

    ps2_key_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_entry(push_entry),
        .pop_ready (key_ready),
        .valid     (key_valid),
        .head      (head),
        .overflow  (overflow)
    );

    assign key_code = head.code;
    assign key_ext  = head.ext;
    assign key_rel  = head.rel;

endmodule
